// File: rtl/frv_mdu_issue.sv
// Issue stage for the multiply/divide unit: accepts one operation, short-circuits
// divide-by-zero and signed-overflow cases, and holds the result until writeback takes it.
module frv_mdu_issue #(
   parameter int XLEN = 32
) (
   input  logic            g_clk,
   input  logic            g_resetn,
   input  logic            flush,
   output logic            g_clk_req,

   input  logic            i_valid,
   output logic            i_ready,
   input  logic [2:0]      i_op,
   input  logic [XLEN-1:0] i_rs1,
   input  logic [XLEN-1:0] i_rs2,
   input  logic [4:0]      i_rd_addr,

   output logic            mdu_valid,
   output logic            mdu_op_mul,
   output logic            mdu_op_mulh,
   output logic            mdu_op_mulhu,
   output logic            mdu_op_mulhsu,
   output logic            mdu_op_div,
   output logic            mdu_op_divu,
   output logic            mdu_op_rem,
   output logic            mdu_op_remu,
   output logic [XLEN-1:0] mdu_rs1,
   output logic [XLEN-1:0] mdu_rs2,
   output logic            mdu_flush,
   input  logic            mdu_ready,
   input  logic [XLEN-1:0] mdu_rd,

   output logic            o_valid,
   input  logic            o_ready,
   output logic [XLEN-1:0] o_result,
   output logic [4:0]      o_rd_addr
);

   localparam int XL = XLEN - 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;

   localparam logic [XL:0] MIN_NEG = {1'b1, {XL{1'b0}}};

   logic [1:0]  state_q, state_d;
   logic [2:0]  op_q;
   logic [XL:0] rs1_q, rs2_q, result_q;
   logic [4:0]  rd_q;

   logic        accept;
   logic        div_zero;
   logic        div_ovf;
   logic        fast;
   logic        run_done;
   logic [XL:0] fast_result;

   // Gating with g_resetn keeps the handshake and flush outputs quiet while in reset.
   assign i_ready   = g_resetn && (state_q == IDLE) && !flush;
   assign accept    = i_valid && i_ready;

   assign div_zero  = i_op[2] && (i_rs2 == '0);
   assign div_ovf   = i_op[2] && !i_op[0] && (i_rs1 == MIN_NEG) && (i_rs2 == '1);
   assign fast      = div_zero || div_ovf;

   always_comb begin
      fast_result = '0;
      if (i_op[1])
         fast_result = div_zero ? i_rs1 : '0;
      else
         fast_result = div_zero ? '1 : MIN_NEG;
   end

   assign mdu_valid = (state_q == RUN);
   // flush wins over a same-cycle completion, so the unit's result is dropped.
   assign run_done  = mdu_valid && mdu_ready && !flush;
   assign mdu_flush = g_resetn && (flush || run_done);
   assign g_clk_req = (state_q != IDLE) || i_valid || flush;

   assign mdu_op_mul    = mdu_valid && (op_q == 3'd0);
   assign mdu_op_mulh   = mdu_valid && (op_q == 3'd1);
   assign mdu_op_mulhsu = mdu_valid && (op_q == 3'd2);
   assign mdu_op_mulhu  = mdu_valid && (op_q == 3'd3);
   assign mdu_op_div    = mdu_valid && (op_q == 3'd4);
   assign mdu_op_divu   = mdu_valid && (op_q == 3'd5);
   assign mdu_op_rem    = mdu_valid && (op_q == 3'd6);
   assign mdu_op_remu   = mdu_valid && (op_q == 3'd7);
   assign mdu_rs1       = rs1_q;
   assign mdu_rs2       = rs2_q;

   assign o_valid   = (state_q == HOLD);
   assign o_result  = result_q;
   assign o_rd_addr = rd_q;

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (accept)   state_d = fast ? HOLD : RUN;
            RUN:     if (run_done) state_d = HOLD;
            HOLD:    if (o_ready)  state_d = IDLE;
            default:               state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         state_q  <= IDLE;
         op_q     <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         rd_q     <= '0;
         result_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q     <= i_op;
            rs1_q    <= i_rs1;
            rs2_q    <= i_rs2;
            rd_q     <= i_rd_addr;
            result_q <= fast_result;
         end else if (run_done) begin
            result_q <= mdu_rd;
         end
      end
   end

endmodule
